sprite_anim_mapper: RTL and testbench

- Parametrised successor to the fixed full-screen sprite mappers.
- Places one animated sprite of W x H texels at a runtime (X,Y) position, with integer power-of-two upscale.
- Steps through FRAMES animation frames stored back-to-back in an external synchronous ROM.
- Emits palette RGB plus an opaque flag so the layer compositor can stack hero, enemy and background layers.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_anim_mapper_if.sv | 21 ++
 rtl/sprite_anim_ctrl.sv | 100 ++++++++++
 rtl/sprite_anim_mapper.sv | 119 +++++++++++
 tb/tb_sprite_anim_mapper.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite layer: screen geometry, pixel coordinates and 4-bit RGB.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [9:0] pix_coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

endpackage

// File: rtl/sprite_anim_mapper_if.sv
// Sprite ROM and palette lookup bus; master is the mapper, slave is the ROM/palette side.
interface sprite_anim_mapper_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_addr, pal_index,
    input  rom_q, pal_red, pal_green, pal_blue
  );

  modport slave (
    input  rom_addr, pal_index,
    output rom_q, pal_red, pal_green, pal_blue
  );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Start-of-frame detect, per-frame position/mirror latch, animation divider and frame counter.
// Optional SPRITE_MIRROR_EN adds a mirror bit latched alongside the position.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES    = 4,
  parameter int unsigned FRAME_DIV = 8,
  parameter int unsigned FIDX_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  pix_coord_t        draw_x_i,
  input  pix_coord_t        draw_y_i,
  input  pix_coord_t        sprite_x_i,
  input  pix_coord_t        sprite_y_i,
  input  logic              anim_en_i,
  input  logic              anim_restart_i,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror_i,
  output logic              mirror_o,
`endif
  output pix_coord_t        pos_x_o,
  output pix_coord_t        pos_y_o,
  output logic [FIDX_W-1:0] frame_idx_o
);

  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic              at0;
  logic              sof;
  logic              at0_q;
  pix_coord_t        pos_x_q, pos_x_d;
  pix_coord_t        pos_y_q, pos_y_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FIDX_W-1:0] frame_q, frame_d;
`ifdef SPRITE_MIRROR_EN
  logic              mirror_q, mirror_d;
`endif

  // Origin held for several cycles still yields a single SOF pulse.
  assign at0 = (draw_x_i == '0) && (draw_y_i == '0);
  assign sof = at0 && !at0_q;

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    div_d   = div_q;
    frame_d = frame_q;
`ifdef SPRITE_MIRROR_EN
    mirror_d = mirror_q;
    if (sof) mirror_d = mirror_i;
`else
`endif
    if (sof) begin
      pos_x_d = sprite_x_i;
      pos_y_d = sprite_y_i;
    end
    if (anim_restart_i) begin
      div_d   = '0;
      frame_d = '0;
    end else if (sof && anim_en_i) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FIDX_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      at0_q    <= 1'b0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      div_q    <= '0;
      frame_q  <= '0;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      at0_q    <= at0;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign frame_idx_o = frame_q;
`ifdef SPRITE_MIRROR_EN
  assign mirror_o    = mirror_q;
`endif

endmodule

// File: rtl/sprite_anim_mapper.sv
// Animated, upscaled sprite layer: 3-cycle pixel pipeline from DrawX/DrawY to RGB + opaque.
// Define SPRITE_MIRROR_EN to add the horizontal mirror input.
module sprite_anim_mapper
  import sprite_pkg::*;
#(
  parameter int unsigned W          = 40,
  parameter int unsigned H          = 66,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned SCALE_SH   = 1,
  parameter int unsigned FRAME_DIV  = 8,
  parameter logic [3:0]  TRANSP_IDX = 4'd0,
  parameter int unsigned ADDR_W     = $clog2(FRAMES * W * H),
  localparam int unsigned FIDX_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  pix_coord_t          DrawX,
  input  pix_coord_t          DrawY,
  input  logic                blank,
  input  pix_coord_t          SpriteX,
  input  pix_coord_t          SpriteY,
  input  logic                anim_en,
  input  logic                anim_restart,
`ifdef SPRITE_MIRROR_EN
  input  logic                mirror,
`endif
  sprite_anim_mapper_if.master mem,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                opaque,
  output logic [FIDX_W-1:0]   frame_idx
);

  localparam int unsigned WS       = W << SCALE_SH;
  localparam int unsigned HS       = H << SCALE_SH;
  localparam int unsigned FRAME_SZ = W * H;

  pix_coord_t  pos_x, pos_y;
`ifdef SPRITE_MIRROR_EN
  logic        mirror_lat;
`endif

  logic [10:0]       lx, ly;
  logic [31:0]       col, row, tex_col;
  logic              hit_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit1_q, blank1_q, hit2_q;
  rgb4_t             rgb_q, rgb_d;
  logic              opaque_d, opaque_q;

  sprite_anim_ctrl #(
    .FRAMES    (FRAMES),
    .FRAME_DIV (FRAME_DIV),
    .FIDX_W    (FIDX_W)
  ) u_ctrl (
    .clk_i          (vga_clk),
    .rst_n_i        (reset_n),
    .draw_x_i       (DrawX),
    .draw_y_i       (DrawY),
    .sprite_x_i     (SpriteX),
    .sprite_y_i     (SpriteY),
    .anim_en_i      (anim_en),
    .anim_restart_i (anim_restart),
`ifdef SPRITE_MIRROR_EN
    .mirror_i       (mirror),
    .mirror_o       (mirror_lat),
`endif
    .pos_x_o        (pos_x),
    .pos_y_o        (pos_y),
    .frame_idx_o    (frame_idx)
  );

  always_comb begin
    // 11-bit difference: bit 10 set means the pixel lies left of / above the sprite.
    lx  = {1'b0, DrawX} - {1'b0, pos_x};
    ly  = {1'b0, DrawY} - {1'b0, pos_y};
    col = 32'(lx[9:0]) >> SCALE_SH;
    row = 32'(ly[9:0]) >> SCALE_SH;
`ifdef SPRITE_MIRROR_EN
    tex_col = mirror_lat ? (W - 1 - col) : col;
`else
    tex_col = col;
`endif
    hit_d = !lx[10] && !ly[10] && (32'(lx[9:0]) < WS) && (32'(ly[9:0]) < HS) && blank;
    rom_addr_d = hit_d ? ADDR_W'(32'(frame_idx) * FRAME_SZ + row * W + tex_col) : '0;

    // Palette answers combinationally from rom_q, so colour and transparency are judged together.
    opaque_d = hit2_q && (mem.rom_q != TRANSP_IDX);
    rgb_d    = '0;
    if (opaque_d) rgb_d = '{r: mem.pal_red, g: mem.pal_green, b: mem.pal_blue};
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      blank1_q   <= 1'b0;
      hit2_q     <= 1'b0;
      rgb_q      <= '0;
      opaque_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit_d;
      blank1_q   <= blank;
      hit2_q     <= hit1_q && blank1_q;
      rgb_q      <= rgb_d;
      opaque_q   <= opaque_d;
    end
  end

  assign mem.rom_addr  = rom_addr_q;
  assign mem.pal_index = mem.rom_q;
  assign red           = rgb_q.r;
  assign green         = rgb_q.g;
  assign blue          = rgb_q.b;
  assign opaque        = opaque_q;

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Directed bench for sprite_anim_mapper: ROM data = low address nibble, palette derived from index.
module tb_sprite_anim_mapper;
  import sprite_pkg::*;

  localparam int unsigned AW = 14;

  logic       vga_clk;
  logic       reset_n;
  pix_coord_t DrawX, DrawY, SpriteX, SpriteY;
  logic       blank, anim_en, anim_restart;
`ifdef SPRITE_MIRROR_EN
  logic       mirror;
`endif
  logic [3:0] red, green, blue;
  logic       opaque;
  logic [1:0] frame_idx;

  int checks;
  int failures;

  sprite_anim_mapper_if #(.ADDR_W(AW)) mif ();

  sprite_anim_mapper #(
    .W          (40),
    .H          (66),
    .FRAMES     (4),
    .SCALE_SH   (1),
    .FRAME_DIV  (8),
    .TRANSP_IDX (4'd0)
  ) dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .SpriteX      (SpriteX),
    .SpriteY      (SpriteY),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
`ifdef SPRITE_MIRROR_EN
    .mirror       (mirror),
`endif
    .mem          (mif.master),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .opaque       (opaque),
    .frame_idx    (frame_idx)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  // Synchronous ROM (1-cycle latency) and combinational palette.
  always @(posedge vga_clk) mif.rom_q <= mif.rom_addr[3:0];
  assign mif.pal_red   = mif.pal_index;
  assign mif.pal_green = ~mif.pal_index;
  assign mif.pal_blue  = mif.pal_index ^ 4'h5;

  logic [AW-1:0] o_addr;
  logic [3:0]    o_pal, o_r, o_g, o_b;
  logic          o_op;

  // Present one pixel, then move to an off-sprite pixel; capture each pipeline stage.
  task automatic run_pixel(input int x, input int y, input logic b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    @(posedge vga_clk); #1;
    o_addr = mif.rom_addr;
    DrawX = 10'd600; DrawY = 10'd470; blank = 1'b1;
    @(posedge vga_clk); #1;
    o_pal = mif.pal_index;
    @(posedge vga_clk); #1;
    o_r = red; o_g = green; o_b = blue; o_op = opaque;
  endtask

  task automatic do_sof(input logic restart);
    DrawX = '0; DrawY = '0; anim_restart = restart;
    @(posedge vga_clk); #1;
    anim_restart = 1'b0;
    DrawX = 10'd600; DrawY = 10'd470;
    @(posedge vga_clk); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; blank = 1'b1; DrawX = 10'd10; DrawY = 10'd10;
    SpriteX = 10'd100; SpriteY = 10'd50; anim_en = 1'b0; anim_restart = 1'b0;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    repeat (3) @(posedge vga_clk);
    #1;
    checks++;
    if ({red, green, blue, opaque, frame_idx, mif.rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state: got rgb=%h%h%h op=%b fr=%0d addr=%0d want all 0",
               red, green, blue, opaque, frame_idx, mif.rom_addr);
    end
    reset_n = 1'b1;
    @(posedge vga_clk); #1;
    checks++;
    if (mif.rom_addr !== 14'd205 || opaque !== 1'b0) begin
      failures++;
      $display("FAIL reset_edge1: got addr=%0d op=%b want addr=205 op=0", mif.rom_addr, opaque);
    end
    @(posedge vga_clk); #1;
    checks++;
    if (opaque !== 1'b0) begin
      failures++;
      $display("FAIL reset_edge2: got op=%b want 0", opaque);
    end
    @(posedge vga_clk); #1;
    checks++;
    if (opaque !== 1'b1 || red !== 4'd13) begin
      failures++;
      $display("FAIL reset_edge3: got op=%b red=%0d want op=1 red=13", opaque, red);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({red, green, blue, opaque, frame_idx, mif.rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_async: got rgb=%h%h%h op=%b addr=%0d want all 0",
               red, green, blue, opaque, mif.rom_addr);
    end
    @(posedge vga_clk); #1;
    reset_n = 1'b1;
    DrawX = 10'd600; DrawY = 10'd470;
    @(posedge vga_clk); #1;
  endtask

  task automatic test_hit;
    do_sof(1'b0);
    run_pixel(101, 53, 1'b1);
    checks++;
    if (o_addr !== 14'd40 || o_pal !== 4'd8) begin
      failures++;
      $display("FAIL hit_addr: got addr=%0d pal=%0d want addr=40 pal=8", o_addr, o_pal);
    end
    checks++;
    if ({o_op, o_r, o_g, o_b} !== {1'b1, 4'd8, 4'd7, 4'd13}) begin
      failures++;
      $display("FAIL hit_rgb: got op=%b rgb=%0d,%0d,%0d want op=1 rgb=8,7,13", o_op, o_r, o_g, o_b);
    end
  endtask

  task automatic test_bounds;
    run_pixel(99, 53, 1'b1);
    checks++;
    if ({o_op, o_r, o_g, o_b, o_addr} !== '0) begin
      failures++;
      $display("FAIL left_edge: got op=%b rgb=%0d,%0d,%0d addr=%0d want all 0", o_op, o_r, o_g, o_b, o_addr);
    end
    run_pixel(180, 53, 1'b1);
    checks++;
    if ({o_op, o_r, o_g, o_b} !== '0) begin
      failures++;
      $display("FAIL right_past: got op=%b rgb=%0d,%0d,%0d want op=0 rgb=0", o_op, o_r, o_g, o_b);
    end
    run_pixel(179, 53, 1'b1);
    checks++;
    if (o_addr !== 14'd79 || {o_op, o_r, o_g, o_b} !== {1'b1, 4'd15, 4'd0, 4'd10}) begin
      failures++;
      $display("FAIL right_last: got addr=%0d op=%b rgb=%0d,%0d,%0d want addr=79 op=1 rgb=15,0,10",
               o_addr, o_op, o_r, o_g, o_b);
    end
    run_pixel(101, 181, 1'b1);
    checks++;
    if (o_addr !== 14'd2600 || o_op !== 1'b1) begin
      failures++;
      $display("FAIL bottom_last: got addr=%0d op=%b want addr=2600 op=1", o_addr, o_op);
    end
    run_pixel(101, 182, 1'b1);
    checks++;
    if (o_op !== 1'b0 || o_r !== 4'd0) begin
      failures++;
      $display("FAIL bottom_past: got op=%b red=%0d want op=0 red=0", o_op, o_r);
    end
    run_pixel(101, 53, 1'b0);
    checks++;
    if (o_op !== 1'b0 || o_addr !== '0) begin
      failures++;
      $display("FAIL blanked: got op=%b addr=%0d want op=0 addr=0", o_op, o_addr);
    end
  endtask

  task automatic test_transparent;
    run_pixel(116, 53, 1'b1);
    checks++;
    if (o_addr !== 14'd48 || o_pal !== 4'd0) begin
      failures++;
      $display("FAIL transp_index: got addr=%0d pal=%0d want addr=48 pal=0", o_addr, o_pal);
    end
    checks++;
    if ({o_op, o_r, o_g, o_b} !== '0) begin
      failures++;
      $display("FAIL transp_rgb: got op=%b rgb=%0d,%0d,%0d want all 0", o_op, o_r, o_g, o_b);
    end
  endtask

  task automatic test_anim;
    anim_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      do_sof(1'b0);
      checks++;
      if (frame_idx !== 2'((k / 8) % 4)) begin
        failures++;
        $display("FAIL anim_step%0d: got frame=%0d want %0d", k, frame_idx, (k / 8) % 4);
      end
      if (k == 8) begin
        run_pixel(101, 53, 1'b1);
        checks++;
        if (o_addr !== 14'd2680 || o_op !== 1'b1) begin
          failures++;
          $display("FAIL frame1_addr: got addr=%0d op=%b want addr=2680 op=1", o_addr, o_op);
        end
      end
    end
    repeat (9) do_sof(1'b0);
    anim_en = 1'b0;
    repeat (10) do_sof(1'b0);
    checks++;
    if (frame_idx !== 2'd1) begin
      failures++;
      $display("FAIL anim_freeze: got frame=%0d want 1", frame_idx);
    end
    anim_en = 1'b1;
    repeat (6) do_sof(1'b0);
    checks++;
    if (frame_idx !== 2'd1) begin
      failures++;
      $display("FAIL anim_pre_restart: got frame=%0d want 1", frame_idx);
    end
    do_sof(1'b1);
    checks++;
    if (frame_idx !== 2'd0) begin
      failures++;
      $display("FAIL restart_priority: got frame=%0d want 0", frame_idx);
    end
    repeat (7) do_sof(1'b0);
    checks++;
    if (frame_idx !== 2'd0) begin
      failures++;
      $display("FAIL restart_div_clear: got frame=%0d want 0", frame_idx);
    end
    do_sof(1'b0);
    checks++;
    if (frame_idx !== 2'd1) begin
      failures++;
      $display("FAIL restart_resume: got frame=%0d want 1", frame_idx);
    end
    anim_en = 1'b0;
    anim_restart = 1'b1;
    @(posedge vga_clk); #1;
    anim_restart = 1'b0;
    checks++;
    if (frame_idx !== 2'd0) begin
      failures++;
      $display("FAIL restart_alone: got frame=%0d want 0", frame_idx);
    end
  endtask

  task automatic test_no_tearing;
    SpriteX = 10'd200;
    run_pixel(101, 53, 1'b1);
    checks++;
    if (o_op !== 1'b1 || o_addr !== 14'd40) begin
      failures++;
      $display("FAIL midframe_old: got op=%b addr=%0d want op=1 addr=40", o_op, o_addr);
    end
    run_pixel(201, 53, 1'b1);
    checks++;
    if (o_op !== 1'b0) begin
      failures++;
      $display("FAIL midframe_new: got op=%b want 0", o_op);
    end
    do_sof(1'b0);
    run_pixel(201, 53, 1'b1);
    checks++;
    if (o_op !== 1'b1 || o_addr !== 14'd40) begin
      failures++;
      $display("FAIL nextframe_new: got op=%b addr=%0d want op=1 addr=40", o_op, o_addr);
    end
    run_pixel(101, 53, 1'b1);
    checks++;
    if (o_op !== 1'b0) begin
      failures++;
      $display("FAIL nextframe_old: got op=%b want 0", o_op);
    end
  endtask

`ifdef SPRITE_MIRROR_EN
  task automatic test_mirror;
    mirror = 1'b1;
    run_pixel(201, 53, 1'b1);
    checks++;
    if (o_addr !== 14'd40) begin
      failures++;
      $display("FAIL mirror_midframe: got addr=%0d want 40", o_addr);
    end
    do_sof(1'b0);
    run_pixel(201, 53, 1'b1);
    checks++;
    if (o_addr !== 14'd79 || o_op !== 1'b1) begin
      failures++;
      $display("FAIL mirror_col: got addr=%0d op=%b want addr=79 op=1", o_addr, o_op);
    end
    mirror = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_hit();
    test_bounds();
    test_transparent();
    test_anim();
    test_no_tearing();
`ifdef SPRITE_MIRROR_EN
    test_mirror();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
